// File: rtl/phy_tx_serializer.sv
// Single-lane transmit serializer: 32-bit words in over valid/ready, one bit per clk_32f out,
// framed by a post-reset comma sync run and IDLE filler bytes between words.
module phy_tx_serializer #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDLE        = 8'h7C,
  parameter int unsigned SYNC_COMMAS = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out,
  output logic        active_out,
  output logic [7:0]  word_cnt
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_DATA
  } state_t;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [3:0]  comma_cnt;
  logic [7:0]  cur_byte;
  logic [31:0] word_reg;
  logic        word_boundary;
  logic [4:0]  comma_next;

  // In DATA, byte_cnt names the next byte to load; 0 means the last byte of the word is on the wire.
  assign word_boundary = (state == S_IDLE) || (state == S_DATA && byte_cnt == 2'd0);
  assign ready_out     = (state != S_SYNC) && !reset && (bit_cnt == 3'd7) && word_boundary;
  assign comma_next    = {1'b0, comma_cnt} + 5'd1;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state      <= S_SYNC;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      comma_cnt  <= '0;
      cur_byte   <= COMMA;
      word_reg   <= '0;
      data_out   <= 1'b0;
      active_out <= 1'b0;
      word_cnt   <= '0;
    end else begin
      data_out <= cur_byte[3'd7 - bit_cnt];
      bit_cnt  <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        case (state)
          S_SYNC: begin
            comma_cnt <= comma_next[3:0];
            if (comma_next < 5'(SYNC_COMMAS)) begin
              cur_byte <= COMMA;
            end else begin
              state      <= S_IDLE;
              cur_byte   <= IDLE;
              active_out <= 1'b1;
            end
          end
          default: begin
            if (word_boundary) begin
              if (valid_in && ready_out) begin
                cur_byte <= data_in[31:24];
                word_reg <= data_in;
                byte_cnt <= 2'd1;
                state    <= S_DATA;
                word_cnt <= word_cnt + 8'd1;
              end else begin
                cur_byte <= IDLE;
                state    <= S_IDLE;
              end
            end else begin
              case (byte_cnt)
                2'd1:    cur_byte <= word_reg[23:16];
                2'd2:    cur_byte <= word_reg[15:8];
                default: cur_byte <= word_reg[7:0];
              endcase
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
